// File: rtl/tl_pkg.sv
// Shared types and lamp pattern constants for the traffic-light lamp monitor.
package tl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RED        = 3'd1,
    RED_YELLOW = 3'd2,
    GREEN      = 3'd3,
    BLINK      = 3'd4,
    YELLOW     = 3'd5,
    ERROR      = 3'd6
  } phase_e;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    ILLEGAL   = 3'd1,
    ORDER     = 3'd2,
    EARLY     = 3'd3,
    OVERRUN   = 3'd4,
    BLINK_ERR = 3'd5
  } err_e;

  // Patterns are {red, yellow, green}.
  localparam logic [2:0] P_RED    = 3'b100;
  localparam logic [2:0] P_RY     = 3'b110;
  localparam logic [2:0] P_GREEN  = 3'b001;
  localparam logic [2:0] P_YELLOW = 3'b010;
  localparam logic [2:0] P_OFF    = 3'b000;

  function automatic logic is_illegal(input logic [2:0] pat);
    return (pat == 3'b011) || (pat == 3'b101) || (pat == 3'b111);
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase duration counter: clear, load-1, saturating increment, period compare.
module tl_phase_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          zero_i,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [CW-1:0] period_i,
  output logic [CW-1:0] cnt_o,
  output logic          at_period_o,
  output logic          odd_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (zero_i) begin
      cnt_o <= '0;
    end else if (load_i) begin
      cnt_o <= CW'(1);
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CW'(1);
    end
  end

  assign at_period_o = (cnt_o == period_i);
  assign odd_o       = cnt_o[0];

endmodule

// File: rtl/tl_lamp_monitor.sv
// Passive lamp-side checker: decodes lamp lines into a phase and checks order,
// durations and the blinking-green pattern; sticky first error, cycle count.
module tl_lamp_monitor
  import tl_pkg::*;
#(
  parameter int unsigned period_red          = 3,
  parameter int unsigned period_yellow_red   = 3,
  parameter int unsigned period_green        = 3,
  parameter int unsigned period_blinky_green = 3,
  parameter int unsigned period_yellow       = 3,
  parameter int unsigned CW                  = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          red_i,
  input  logic          yellow_i,
  input  logic          green_i,
  input  logic          clear_i,
  output logic [2:0]    phase_o,
  output logic          phase_valid_o,
  output logic          err_o,
  output logic [2:0]    err_code_o,
  output logic [CW-1:0] cycles_o
);

  phase_e        state_q, nxt_state, adv_state;
  err_e          fault;
  logic [2:0]    pat, own_pat, nxt_pat;
  logic [CW-1:0] period, cnt;
  logic          at_period, odd;
  logic          t_zero, t_load, t_inc, wrap;

  tl_phase_timer #(.CW(CW)) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .zero_i      (t_zero),
    .load_i      (t_load),
    .inc_i       (t_inc),
    .period_i    (period),
    .cnt_o       (cnt),
    .at_period_o (at_period),
    .odd_o       (odd)
  );

  // Per-phase table: own pattern, entry pattern of the successor, successor, period.
  always_comb begin
    own_pat   = P_RED;
    nxt_pat   = P_RY;
    adv_state = RED_YELLOW;
    period    = CW'(period_red);
    case (state_q)
      RED_YELLOW: begin own_pat = P_RY;     nxt_pat = P_GREEN;  adv_state = GREEN;  period = CW'(period_yellow_red);   end
      GREEN:      begin own_pat = P_GREEN;  nxt_pat = P_OFF;    adv_state = BLINK;  period = CW'(period_green);        end
      BLINK:      begin own_pat = P_OFF;    nxt_pat = P_YELLOW; adv_state = YELLOW; period = CW'(period_blinky_green); end
      YELLOW:     begin own_pat = P_YELLOW; nxt_pat = P_RED;    adv_state = RED;    period = CW'(period_yellow);       end
      default:    ;
    endcase
  end

  always_comb begin
    pat       = {red_i, yellow_i, green_i};
    nxt_state = state_q;
    fault     = NONE;
    t_zero    = 1'b0;
    t_load    = 1'b0;
    t_inc     = 1'b0;
    wrap      = 1'b0;
    if (clear_i) begin
      nxt_state = IDLE;
      t_zero    = 1'b1;
    end else if (state_q != ERROR) begin
      if (is_illegal(pat)) begin
        fault = ILLEGAL;
      end else if (state_q == IDLE) begin
        if (pat == P_RED) begin
          nxt_state = RED;
          t_load    = 1'b1;
        end
      end else if (pat == nxt_pat) begin
        if (cnt < period) begin
          fault = EARLY;
        end else begin
          nxt_state = adv_state;
          t_load    = 1'b1;
          wrap      = (state_q == YELLOW);
        end
      end else if ((state_q == BLINK) && ((pat == P_OFF) || (pat == P_GREEN))) begin
        // Incoming sample will be counted as cnt+1; green is lit on even counts.
        if (pat[0] != odd)   fault = BLINK_ERR;
        else if (at_period)  fault = OVERRUN;
        else                 t_inc = 1'b1;
      end else if ((state_q != BLINK) && (pat == own_pat)) begin
        if (at_period) fault = OVERRUN;
        else           t_inc = 1'b1;
      end else begin
        fault = ORDER;
      end
    end
    if (fault != NONE) nxt_state = ERROR;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      phase_valid_o <= 1'b0;
      err_o         <= 1'b0;
      err_code_o    <= NONE;
      cycles_o      <= '0;
    end else begin
      state_q       <= nxt_state;
      phase_valid_o <= (nxt_state != IDLE) && (nxt_state != ERROR);
      if (clear_i) begin
        err_o      <= 1'b0;
        err_code_o <= NONE;
      end else if (fault != NONE) begin
        err_o      <= 1'b1;
        err_code_o <= fault;
      end
      if (wrap) cycles_o <= cycles_o + CW'(1);
    end
  end

  assign phase_o = state_q;

endmodule

// File: tb/tb_tl_lamp_monitor.sv
// Self-checking bench: directed scenarios plus randomized lamp sequences
// compared against a behavioural model of the monitor.
module tb_tl_lamp_monitor;

  localparam int unsigned CW = 4;
  localparam int unsigned PER = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          red_i = 1'b0, yellow_i = 1'b0, green_i = 1'b0, clear_i = 1'b0;
  logic [2:0]    phase_o;
  logic          phase_valid_o, err_o;
  logic [2:0]    err_code_o;
  logic [CW-1:0] cycles_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  tl_lamp_monitor #(
    .period_red          (PER),
    .period_yellow_red   (PER),
    .period_green        (PER),
    .period_blinky_green (PER),
    .period_yellow       (PER),
    .CW                  (CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .red_i         (red_i),
    .yellow_i      (yellow_i),
    .green_i       (green_i),
    .clear_i       (clear_i),
    .phase_o       (phase_o),
    .phase_valid_o (phase_valid_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o),
    .cycles_o      (cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: phase index 0..6, dwell count, first error code, completed cycles.
  int unsigned m_phase, m_cnt, m_code, m_cycles;
  bit          m_err;
  // Steady pattern of each phase, and the pattern that opens its successor.
  int unsigned own_pat[6] = '{0, 4, 6, 1, 0, 2};
  int unsigned succ_pat[6] = '{0, 6, 1, 0, 2, 4};

  function void m_reset();
    m_phase = 0; m_cnt = 0; m_code = 0; m_cycles = 0; m_err = 0;
  endfunction

  function void m_step(input int unsigned pat, input bit clr);
    int unsigned f;
    f = 0;
    if (clr) begin
      m_phase = 0; m_cnt = 0; m_code = 0; m_err = 0;
      return;
    end
    if (m_phase == 6) return;
    if (pat == 3 || pat == 5 || pat == 7) f = 1;
    else if (m_phase == 0) begin
      if (pat == 4) begin m_phase = 1; m_cnt = 1; end
    end else if (pat == succ_pat[m_phase]) begin
      if (m_cnt < PER) f = 3;
      else begin
        if (m_phase == 5) m_cycles = (m_cycles + 1) % (1 << CW);
        m_phase = (m_phase == 5) ? 1 : m_phase + 1;
        m_cnt = 1;
      end
    end else if (m_phase == 4 && pat <= 1) begin
      if ((pat == 1) != (((m_cnt + 1) % 2) == 0)) f = 5;
      else if (m_cnt == PER) f = 4;
      else m_cnt++;
    end else if (m_phase != 4 && pat == own_pat[m_phase]) begin
      if (m_cnt == PER) f = 4;
      else if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else f = 2;
    if (f != 0) begin
      m_phase = 6; m_err = 1; m_code = f;
    end
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".phase"}, 32'(phase_o), m_phase);
    check_eq({tag, ".valid"}, 32'(phase_valid_o), 32'(m_phase >= 1 && m_phase <= 5));
    check_eq({tag, ".err"}, 32'(err_o), 32'(m_err));
    check_eq({tag, ".code"}, 32'(err_code_o), m_code);
    check_eq({tag, ".cycles"}, 32'(cycles_o), m_cycles);
  endtask

  task automatic step(input int unsigned pat, input bit clr, input string tag);
    {red_i, yellow_i, green_i} = pat[2:0];
    clear_i = clr;
    @(posedge clk_i);
    m_step(pat, clr);
    #1;
    compare_all(tag);
    clear_i = 1'b0;
  endtask

  task automatic steps(input int unsigned pat, input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) step(pat, 1'b0, tag);
  endtask

  task automatic feed_cycle(input bit perturb);
    int unsigned len, p;
    bit c;
    for (int unsigned ph = 1; ph <= 5; ph++) begin
      len = PER;
      if (perturb && $urandom_range(7) == 0) len = $urandom_range(1, PER + 1);
      for (int unsigned k = 0; k < len; k++) begin
        p = (ph == 4) ? (k % 2) : own_pat[ph];
        c = 1'b0;
        if (perturb && $urandom_range(19) == 0) p = $urandom_range(7);
        if (perturb && $urandom_range(39) == 0) c = 1'b1;
        step(p, c, "rand");
      end
    end
  endtask

  initial begin
    m_reset();
    #1;
    compare_all("reset");
    #10 rst_i = 1'b0;

    // Nominal sequence through one full cycle
    steps(4, 3, "nom.red"); steps(6, 3, "nom.ry"); steps(1, 3, "nom.green");
    step(0, 0, "nom.blink"); step(1, 0, "nom.blink"); step(0, 0, "nom.blink");
    check_eq("nom.in_blink", 32'(phase_o), 4);
    steps(2, 3, "nom.yellow");
    check_eq("nom.in_yellow", 32'(phase_o), 5);
    step(4, 0, "nom.wrap");
    check_eq("nom.red_again", 32'(phase_o), 1);
    check_eq("nom.cycles", 32'(cycles_o), 1);
    check_eq("nom.no_err", 32'(err_o), 0);

    // Early advance
    step(0, 1, "clr"); steps(4, 2, "early.red"); step(6, 0, "early.ry");
    check_eq("early.phase", 32'(phase_o), 6);
    check_eq("early.code", 32'(err_code_o), 3);
    check_eq("early.valid", 32'(phase_valid_o), 0);

    // Overrun in green, then a later fault must not overwrite the code
    step(0, 1, "clr"); steps(4, 3, "ovr.red"); steps(6, 3, "ovr.ry"); steps(1, 4, "ovr.green");
    check_eq("ovr.code", 32'(err_code_o), 4);
    step(5, 0, "ovr.sticky");
    check_eq("ovr.sticky_code", 32'(err_code_o), 4);

    // Illegal pattern, clear, resynchronise
    step(0, 1, "clr"); step(4, 0, "ill.red"); step(5, 0, "ill.bad");
    check_eq("ill.code", 32'(err_code_o), 1);
    step(5, 1, "ill.clear_wins");
    check_eq("ill.clr_phase", 32'(phase_o), 0);
    check_eq("ill.clr_err", 32'(err_o), 0);
    step(4, 0, "ill.resync");
    check_eq("ill.resync_phase", 32'(phase_o), 1);

    // Blink mismatch
    step(0, 1, "clr"); steps(4, 3, "bl.red"); steps(6, 3, "bl.ry"); steps(1, 3, "bl.green");
    step(0, 0, "bl.first"); step(0, 0, "bl.second");
    check_eq("bl.code", 32'(err_code_o), 5);

    // Asynchronous reset mid-green
    step(0, 1, "clr"); steps(4, 3, "rst.red"); steps(6, 3, "rst.ry"); steps(1, 2, "rst.green");
    #2 rst_i = 1'b1;
    #1 m_reset();
    compare_all("rst.async");
    #2 rst_i = 1'b0;
    steps(0, 2, "rst.idle");
    check_eq("rst.idle_phase", 32'(phase_o), 0);
    step(4, 0, "rst.red_again");
    check_eq("rst.red_phase", 32'(phase_o), 1);

    // Clean cycles across the cycles_o wrap boundary
    steps(4, PER - 1, "wrap.lead");
    steps(6, PER, "wrap.ry"); steps(1, PER, "wrap.green");
    step(0, 0, "wrap.blink"); step(1, 0, "wrap.blink"); step(0, 0, "wrap.blink");
    steps(2, PER, "wrap.yellow");
    for (int unsigned i = 0; i < (1 << CW); i++) feed_cycle(1'b0);
    check_eq("wrap.cycles", 32'(cycles_o), m_cycles);

    // Randomized perturbed sequences with recovery
    for (int unsigned i = 0; i < 60; i++) begin
      if (m_phase == 6 || m_phase == 0) begin
        if (m_phase == 6) step(0, 1'b1, "rand.clr");
        steps($urandom_range(2), $urandom_range(0, 2), "rand.idle");
        step(4, 1'b0, "rand.sync");
        steps(4, PER - 1, "rand.red");
        for (int unsigned ph = 2; ph <= 5; ph++) begin
          if (ph == 4) begin
            step(0, 0, "rand.blink"); step(1, 0, "rand.blink"); step(0, 0, "rand.blink");
          end else steps(own_pat[ph], PER, "rand.lead");
        end
      end
      feed_cycle(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tl_lamp_monitor.md
# tl_lamp_monitor

Passive checker on the lamp side of the traffic-light controller. Samples the red/yellow/green lamp lines every clock, decodes them into a traffic-light phase, and checks phase order, phase durations and the blinking-green pattern against the same period parameters the controller uses. Reports the decoded phase, a sticky first-error code and a count of completed light cycles. Sits beside the controller at top level and in benches as the receiving end of the lamp interface.

## Interface
- period_red, 3: required cycles of pattern red only (100).
- period_yellow_red, 3: required cycles of red+yellow (110).
- period_green, 3: required cycles of steady green (001).
- period_blinky_green, 3: required cycles of blinking green.
- period_yellow, 3: required cycles of yellow only (010).
- CW, 8: width of the duration counter and of cycles_o. Every period must be in 1..2^CW-2.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, asynchronous, active-high.
- red_i, yellow_i, green_i  in  1 each  lamp lines, written as pattern {red,yellow,green}.
- clear_i  in  1  synchronous one-cycle pulse; leaves ERROR and clears error status.
- phase_o  out  3  decoded phase (phase_e).
- phase_valid_o  out  1  high in RED..YELLOW, low in IDLE and ERROR.
- err_o  out  1  sticky error flag.
- err_code_o  out  3  first error since reset or clear (err_e).
- cycles_o  out  CW  count of completed sequences; wraps modulo 2^CW.

## Operation
- FSM states (phase_e): IDLE=0, RED=1, RED_YELLOW=2, GREEN=3, BLINK=4, YELLOW=5, ERROR=6.
- Legal order: RED→RED_YELLOW→GREEN→BLINK→YELLOW→RED.
- Patterns: 100 RED, 110 RED_YELLOW, 001 GREEN, 010 YELLOW. In BLINK, 000/001 alternate.
- Illegal patterns: 011, 101, 111. Any state except ERROR goes to ERROR with code ILLEGAL=1.
- Duration counter cnt: set to 1 on the cycle a phase is entered, incremented on each further cycle of that phase. Saturates at 2^CW-1.
- IDLE: 000 keeps IDLE. 100 enters RED. 110, 001 or 010 stays IDLE with no error (the monitor synchronises on red).
- In a steady phase with period P:
  - Same pattern with cnt==P → ERROR, OVERRUN=4.
  - Next phase's pattern with cnt<P → ERROR, EARLY=3.
  - Next phase's pattern with cnt==P → advance.
  - Any other legal pattern → ERROR, ORDER=2.
- GREEN→BLINK: a 000 sample enters BLINK with cnt=1.
- BLINK:
  - Expected green bit = 0 when cnt is odd, 1 when cnt is even, so the pattern runs 000,001,000,…
  - Mismatch → ERROR, BLINK_ERR=5.
  - Another 000/001 with cnt==P → OVERRUN.
  - 010 with cnt<P → EARLY; with cnt==P → YELLOW.
  - 100 or 110 → ORDER.
- YELLOW→RED increments cycles_o, modulo 2^CW.
- ERROR:
  - Absorbing state. Lamp inputs are ignored.
  - err_code_o holds the first code; later faults do not overwrite it.
  - clear_i → IDLE, err_o=0, err_code_o=0, cnt=0. cycles_o is kept.
- clear_i outside ERROR → IDLE with errors cleared; the sequence resynchronises on the next 100.

## Timing
- All outputs are registered. Pattern sampled at edge k is reflected on outputs after edge k (1-cycle latency).
- An error is flagged at the edge that samples the offending pattern.
- Reset values: phase_o=IDLE, phase_valid_o=0, err_o=0, err_code_o=0, cycles_o=0, cnt=0.
- rst_i asserted mid-sequence forces the reset values immediately, without waiting for a clock edge.
- clear_i and a fault in the same cycle: clear_i wins; the next state is IDLE and no error is recorded.
- cycles_o increments on the same edge that phase_o becomes RED from YELLOW.

## Structure
- Package tl_pkg: phase_e; err_e (NONE=0, ILLEGAL=1, ORDER=2, EARLY=3, OVERRUN=4, BLINK_ERR=5); lamp pattern constants P_RED, P_RY, P_GREEN, P_YELLOW, P_OFF.
- Sub-module tl_phase_timer:
  - CW-bit counter with load-1, increment and saturate.
  - Outputs cnt, at_period (cnt==P) and odd (cnt[0]).
  - P is selected by the FSM from the period parameters.

## Test plan
- Nominal, all periods 3. Feed 100×3, 110×3, 001×3, 000, 001, 000, 010×3, then 100 → phase_o steps 1,2,3,4,5,1; err_o=0; cycles_o=1 after the final 100 edge.
- Early: 100×2 then 110 → phase_o=6, err_code_o=3, phase_valid_o=0 after that edge.
- Overrun: valid RED and RED_YELLOW, then 001×4 → err_code_o=4 at the 4th green sample. Then 101 → err_code_o stays 4.
- Illegal then clear: 101 in RED → err_code_o=1. Pulse clear_i → phase_o=0, err_o=0. Feed 100 → phase_o=1.
- Blink mismatch: after 001×3, feed 000 then 000 → err_code_o=5 on the second 000.
- Reset mid-GREEN: assert rst_i between edges → all outputs at reset values before the next edge. Release, feed 000×2 then 100 → phase_o IDLE, then RED.
